// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage
// and its prefetch queue.
package cpu_pkg;

   localparam logic [31:0] NOP_INST = 32'h0;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DROP
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {inst, pc4} pairs between
// instruction memory and decode.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fq_entry_t     wdata,
   output logic [CW-1:0] count,
   output fq_entry_t     head
);

   fq_entry_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset; head is only used when count != 0.
   always_ff @(posedge clk_i) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, runs the imem req/ack
// handshake and feeds decode from a prefetch queue.
module inst_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc4_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   addr_inc;
   logic          req_q;
   logic [CW-1:0] count;
   logic [CW:0]   cnt_next;
   logic          valid;
   logic          push;
   logic          pop;
   logic          space;
   fq_entry_t     wdata;
   fq_entry_t     head;

   assign addr_inc = addr_q + PC_STEP;
   assign valid    = (count != '0);
   assign pop      = valid & ~stall_i & ~redirect_i;
   assign push     = (state_q == BUSY) & imem_ack_i & ~redirect_i;
   assign wdata    = '{inst: imem_data_i, pc4: addr_inc};

   // Occupancy after this cycle's flush/pop/push settles.
   always_comb begin
      cnt_next = '0;
      if (!redirect_i) begin
         cnt_next = (CW+1)'(count) + (CW+1)'(push)
                  - (CW+1)'(pop);
      end
   end

   assign space = (cnt_next < (CW+1)'(DEPTH));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      unique case (state_q)
         IDLE: begin
            if (redirect_i) begin
               pc_d = redirect_pc_i;
            end else if (space) begin
               state_d = BUSY;
               addr_d  = pc_q;
            end
         end
         BUSY: begin
            if (redirect_i) begin
               pc_d    = redirect_pc_i;
               state_d = imem_ack_i ? IDLE : DROP;
            end else if (imem_ack_i) begin
               pc_d = addr_inc;
               if (space) begin
                  addr_d = addr_inc;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DROP: begin
            if (redirect_i) pc_d = redirect_pc_i;
            if (imem_ack_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= (state_d != IDLE);
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .pop   (pop),
      .flush (redirect_i),
      .wdata (wdata),
      .count (count),
      .head  (head)
   );

   assign imem_req_o  = req_q;
   assign imem_addr_o = addr_q;
   assign valid_o     = valid;
   assign inst_o      = valid ? head.inst : NOP_INST;
   assign pc4_o       = valid ? head.pc4 : 32'h0;

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and runs a req/ack handshake with a variable-latency instruction memory. Returned instructions are buffered in a small prefetch queue, and the head entry is presented to decode together with its PC+4. The block honours decode stalls (IF/ID write disabled) and flushes on branch/jump redirects.

## Interface
Parameters:
- DEPTH, 4: prefetch queue entries; power of 2, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk_i  in  1  clock; everything on posedge. One clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous, active-high reset.
- imem_req_o  out  1  fetch request, registered.
- imem_addr_o  out  32  fetch address, registered; stable while imem_req_o=1.
- imem_ack_i  in  1  memory accepted the request and imem_data_i is valid this cycle.
- imem_data_i  in  32  fetched instruction.
- stall_i  in  1  decode not accepting (IF/ID write disabled).
- redirect_i  in  1  taken branch/jump from ID.
- redirect_pc_i  in  32  redirect target.
- valid_o  out  1  queue head valid.
- inst_o  out  32  queue head instruction; 32'h0 (NOP) when valid_o=0.
- pc4_o  out  32  queue head fetch address + 4; 0 when valid_o=0.

## Operation
- At most one memory request is outstanding at a time.
- imem_req_o stays high, with the address unchanged, until imem_ack_i is sampled high.
- FSM states:
  - IDLE: req=0.
  - BUSY: req=1; the data will be kept.
  - DROP: req=1; the data will be discarded.
- IDLE→BUSY when cnt_next < DEPTH. cnt_next is the queue count after this cycle's pop/flush. On this transition imem_addr_o ← fetch_pc.
- BUSY with ack and no redirect:
  - push {imem_data_i, imem_addr_o+4};
  - fetch_pc ← imem_addr_o+4, wrapping mod 2^32;
  - if cnt_next (including this push) < DEPTH, stay BUSY and set imem_addr_o ← imem_addr_o+4;
  - otherwise go IDLE.
- BUSY with redirect: fetch_pc ← redirect_pc_i. If ack is also high this cycle, the data is dropped and the FSM goes to IDLE; otherwise it goes to DROP.
- DROP with ack: the data is discarded and the FSM goes to IDLE. A redirect while in DROP only updates fetch_pc.
- IDLE with redirect: fetch_pc ← redirect_pc_i. The IDLE→BUSY issue is suppressed that cycle, so the next request uses the new PC.
- Pop: occurs when valid_o=1 and stall_i=0 and redirect_i=0.
- Redirect: clears the whole queue the same cycle. Redirect has priority over pop and push.
- Space check: the queue can never overflow, because a request is only issued when a slot is free and the count cannot rise while that request is outstanding.
- Reset values (at the clock edge where rst_i=1):
  - state IDLE; fetch_pc=RESET_PC; imem_addr_o=RESET_PC; imem_req_o=0;
  - queue empty, so valid_o=0, inst_o=0, pc4_o=0.
- Reset during BUSY or DROP abandons the outstanding request. An ack arriving in the cycle right after reset is ignored, because the FSM is in IDLE.

## Timing
- First request: imem_req_o=1 one cycle after rst_i falls.
- Ack in cycle t → valid_o=1 with that instruction in cycle t+1. No bypass from imem_data_i to inst_o.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle sustained.
- Redirect in cycle t:
  - valid_o=0 in t+1;
  - a request to redirect_pc_i is issued at the earliest in t+2 if the FSM was IDLE or BUSY-with-ack in t, otherwise one cycle after the DROP ack.
- Full queue with stall_i=1: req drops to 0. Release the stall for one cycle → a pop, then req=1 again the next cycle.

## Structure
- Shared package cpu_pkg:
  - NOP_INST = 32'h0;
  - PC_STEP = 32'd4;
  - fetch state enum {IDLE, BUSY, DROP}.
- Sub-module fetch_queue: synchronous FIFO of DEPTH entries, 64 bits wide {inst, pc4}.
  - Ports: push, pop, flush, count, head.
  - flush has priority over push and pop.
  - Pointers wrap mod DEPTH; count is $clog2(DEPTH)+1 bits.

## Test plan
- Reset, then zero-wait memory returning imem_addr_o as data, stall_i=0 → addresses 0,4,8,…, each issued one cycle after the previous; valid_o first high 2 cycles after rst_i falls, with inst_o=0, pc4_o=4.
- Hold stall_i=1 with DEPTH=4 → exactly 4 acks accepted, then imem_req_o=0 and valid_o=1 with inst_o=0; release the stall for 1 cycle → one pop, then one new request at addr 16.
- Memory with 3-cycle ack latency; redirect_i=1, redirect_pc_i=0x100 one cycle after req → addr held until ack, that data never appears on inst_o, next request to 0x100.
- Redirect to 0x200 in the same cycle as ack in BUSY → data dropped, queue empty next cycle, next request to 0x200.
- Queue holding 3 entries with stall_i=0 and redirect_i=1 → no pop credited, valid_o=0 next cycle, pc4_o=0.
- Assert rst_i while in DROP, with ack arriving the following cycle → ack ignored, outputs at reset values, next request to RESET_PC.
